// File: rtl/config_pkg.sv
// System-wide constants for the UART ALU: clock and line rate.
package config_pkg;
  localparam int unsigned CLK_FREQ_HZ = 12_000_000;
  localparam int unsigned BAUD_RATE   = 115_200;
endpackage : config_pkg

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receiver and transmitter.
package uart_pkg;
  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;
endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// Serial line plus byte valid/ready and error pulses between uart_rx and its consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx_i;
  logic [UART_DATA_BITS-1:0] data_o;
  logic                      valid_o;
  logic                      ready_i;
  logic                      frame_err_o;
  logic                      overrun_o;

  modport master (
    input  rx_i,
    input  ready_i,
    output data_o,
    output valid_o,
    output frame_err_o,
    output overrun_o
  );

  modport slave (
    output rx_i,
    output ready_i,
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  overrun_o
  );
endinterface : uart_rx_if

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is selectable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_async,
  output logic o_sync
);
  logic r_meta;
  logic r_sync;

  // NOTE: non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver: bit-counter frame FSM feeding a single-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = config_pkg::CLK_FREQ_HZ,
  parameter int unsigned BAUD_RATE   = config_pkg::BAUD_RATE
) (
  input  logic      clk_i,
  input  logic      rst_i,
  uart_rx_if.master bus
);
  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  if (DIV < 4) begin : g_div_too_small
    $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE = %0d, must be at least 4", DIV);
  end

  uart_rx_state_e            r_state, w_next_state;
  logic [CNT_W-1:0]          r_bit_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [UART_DATA_BITS-1:0] r_shift, r_data;
  logic                      r_valid, r_frame_err, r_overrun;
  logic [1:0]                r_settle;
  logic                      r_armed;
  logic                      w_rx_s, w_half_hit, w_bit_hit;
  logic                      w_cnt_clr, w_idx_clr, w_sample, w_byte_done, w_frame_err;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_async (bus.rx_i),
    .o_sync  (w_rx_s)
  );

  assign w_half_hit = (r_bit_cnt == HALF_LAST);
  assign w_bit_hit  = (r_bit_cnt == BIT_LAST);

  // The synchronizer comes out of reset high regardless of the line; start detection waits
  // until a genuinely sampled idle level is seen, so a reset mid-frame cannot spawn a ghost frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_settle <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_settle <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_rx_s) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_idx_clr    = 1'b0;
    w_sample     = 1'b0;
    w_byte_done  = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (r_armed && !w_rx_s) w_next_state = START;
      end
      START: begin
        if (w_half_hit) begin
          w_cnt_clr    = 1'b1;
          w_idx_clr    = 1'b1;
          w_next_state = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_bit_hit) begin
          w_cnt_clr = 1'b1;
          w_sample  = 1'b1;
          if (r_idx == IDX_LAST) w_next_state = STOP;
        end
      end
      STOP: begin
        if (w_bit_hit) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_byte_done  = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_next_state = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_rx_s) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
    end else begin
      r_bit_cnt <= w_cnt_clr ? '0 : r_bit_cnt + 1'b1;
      if (w_idx_clr)     r_idx <= '0;
      else if (w_sample) r_idx <= r_idx + 1'b1;
      if (w_sample) r_shift[r_idx] <= w_rx_s;
    end
  end

  // A completing byte replaces the held one only if that one is leaving this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;
      if (w_byte_done) begin
        if (!r_valid || bus.ready_i) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_o      = r_data;
  assign bus.valid_o     = r_valid;
  assign bus.frame_err_o = r_frame_err;
  assign bus.overrun_o   = r_overrun;
endmodule : uart_rx
